// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Control/data bundle types shared by the CPU pipeline stage regs.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

  typedef struct packed {
    logic       RegDst;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       Branch;
    logic       Jump;
    logic       ExtOp;
    logic [1:0] ALUOp;
  } ctrl_t;

  // Natural width of the decoded control bundle; stage instances may pad it.
  localparam int CTRL_BUNDLE_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_val;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_result;
  } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Brief    : valid/ready handshake bundle carrying data and control words.
// Revision : 1.0
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buf
// Brief    : Second (skid) entry of a pipeline stage, with its valid flag.
// Revision : 1.0
// ============================================================================
module pipe_skid_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Parametrised pipeline stage register with handshake, stall, flush
//            and optional skid entry. Define PIPE_STAGE_PERF_EN to add the
//            saturating stall/bubble performance counters.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  pipe_stage_reg_if.slave  up_if,
  pipe_stage_reg_if.master dn_if,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [CTRL_W-1:0] c_ctrl_bubble = CTRL_W'(CTRL_NOP);

  logic              w_go;
  logic              w_out_fire;
  logic              w_in_fire;
  logic              w_ready;
  logic              w_skid_valid;
  logic              w_skid_load;
  logic              w_skid_drain;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  assign w_go         = dn_if.ready & ~stall_i;
  assign w_out_fire   = valid_q & w_go;
  assign w_in_fire    = up_if.valid & w_ready;
  assign w_skid_load  = w_in_fire & valid_q & ~w_out_fire;
  assign w_skid_drain = w_out_fire & w_skid_valid;

  // The skid entry is older than any incoming one, so it refills main first.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = c_ctrl_bubble;
    end else if (w_out_fire || !valid_q) begin
      if (w_skid_valid) begin
        valid_d = 1'b1;
        data_d  = w_skid_data;
        ctrl_d  = w_skid_ctrl;
      end else if (w_in_fire) begin
        valid_d = 1'b1;
        data_d  = up_if.data;
        ctrl_d  = up_if.ctrl;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_skid_load),
        .drain_i (w_skid_drain),
        .flush_i (flush_i),
        .data_i  (up_if.data),
        .ctrl_i  (up_if.ctrl),
        .valid_o (w_skid_valid),
        .data_o  (w_skid_data),
        .ctrl_o  (w_skid_ctrl)
      );
      assign w_ready = ~w_skid_valid;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign w_skid_ctrl  = '0;
      assign w_ready      = ~valid_q | w_go;
    end
  endgenerate

  assign up_if.ready = w_ready;
  assign dn_if.valid = valid_q;
  assign dn_if.data  = data_q;
  // Bubbles never carry control bits, so no stray RegWrite/MemWrite leaks out.
  assign dn_if.ctrl  = valid_q ? ctrl_q : c_ctrl_bubble;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (valid_q && !w_go && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!valid_q && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench driving SKID=0 and SKID=1 stages in lockstep
//            against a capacity-limited FIFO reference model.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 16;
  localparam int NW = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          stall  = 1'b0;
  logic          flush  = 1'b0;
  logic          v_in   = 1'b0;
  logic          rdy_in = 1'b0;
  logic [DW-1:0] d_in   = '0;
  logic [CW-1:0] c_in   = '0;
  logic [NW-1:0] sc0, bc0, sc1, bc1;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up0 (), dn0 (), up1 (), dn1 ();

  assign up0.valid = v_in;
  assign up0.data  = d_in;
  assign up0.ctrl  = c_in;
  assign dn0.ready = rdy_in;
  assign up1.valid = v_in;
  assign up1.data  = d_in;
  assign up1.ctrl  = c_in;
  assign dn1.ready = rdy_in;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut0 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .up_if        (up0),
    .dn_if        (dn0),
    .stall_i      (stall),
    .flush_i      (flush),
    .stall_cnt_o  (sc0),
    .bubble_cnt_o (bc0)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut1 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .up_if        (up1),
    .dn_if        (dn1),
    .stall_i      (stall),
    .flush_i      (flush),
    .stall_cnt_o  (sc1),
    .bubble_cnt_o (bc1)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t mq [2][2];
  int   mn [2];
  int   m_stall [2];
  int   m_bub [2];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > (2**NW - 1)) ? (2**NW - 1) : n;
  endfunction

  // One clock of stimulus: drive at negedge, check settled outputs, advance model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r, input logic s, input logic f, input logic rn);
    logic          ov [2];
    logic          ordy [2];
    logic [DW-1:0] od [2];
    logic [CW-1:0] oc [2];
    logic [NW-1:0] osc [2];
    logic [NW-1:0] obc [2];
    @(negedge clk);
    v_in = v; d_in = d; c_in = c; rdy_in = r; stall = s; flush = f; rst_n = rn;
    #1;
    ov[0] = dn0.valid; ordy[0] = up0.ready; od[0] = dn0.data; oc[0] = dn0.ctrl;
    ov[1] = dn1.valid; ordy[1] = up1.ready; od[1] = dn1.data; oc[1] = dn1.ctrl;
    osc[0] = sc0; obc[0] = bc0; osc[1] = sc1; obc[1] = bc1;
    for (int k = 0; k < 2; k++) begin
      logic go, ev, er, ofire, ifire;
      int   cap;
      cap = (k == 0) ? 1 : 2;
      if (!rn) begin
        mn[k] = 0; m_stall[k] = 0; m_bub[k] = 0;
      end
      go = r & ~s;
      ev = (mn[k] > 0);
      er = (k == 0) ? (mn[k] == 0 || go) : (mn[k] < cap);
      check_value($sformatf("s%0d_valid_o", k), 64'(ov[k]), 64'(ev));
      check_value($sformatf("s%0d_ready_o", k), 64'(ordy[k]), 64'(er));
      check_value($sformatf("s%0d_ctrl_o", k), 64'(oc[k]), ev ? 64'(mq[k][0].c) : 64'd0);
      if (ev) check_value($sformatf("s%0d_data_o", k), od[k], mq[k][0].d);
      if (!rn) check_value($sformatf("s%0d_data_rst", k), od[k], 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      check_value($sformatf("s%0d_stall_cnt", k), 64'(osc[k]), 64'(sat(m_stall[k])));
      check_value($sformatf("s%0d_bubble_cnt", k), 64'(obc[k]), 64'(sat(m_bub[k])));
`else
      check_value($sformatf("s%0d_stall_cnt", k), 64'(osc[k]), 64'd0);
      check_value($sformatf("s%0d_bubble_cnt", k), 64'(obc[k]), 64'd0);
`endif
      if (rn) begin
        ofire = ev & go;
        ifire = v & er;
        if (ev && !go) m_stall[k]++;
        if (!ev) m_bub[k]++;
        if (f) begin
          mn[k] = 0;
        end else begin
          if (ofire) begin
            mq[k][0] = mq[k][1];
            mn[k]--;
          end
          if (ifire && mn[k] < cap) begin
            mq[k][mn[k]] = '{d: d, c: c};
            mn[k]++;
          end
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; m_stall[k] = 0; m_bub[k] = 0;
    end

    // reset
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // back-to-back streaming 0x1..0x8
    for (int i = 1; i <= 8; i++)
      cycle(1'b1, DW'(i), CW'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // hold 0x5 under stall while 0x6 is offered
    cycle(1'b1, 64'h5, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 64'h6, 16'h0066, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 64'h6, 16'h0066, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // flush with an entry held and 0xA arriving
    cycle(1'b1, 64'h9, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 64'hA, 16'h00AA, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // bubble gating
    repeat (3) cycle(1'b0, 64'hDEAD, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // reset with the skid entry full
    cycle(1'b1, 64'h1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 64'h2, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 64'h3, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 64'h4, 16'h0044, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // 20 stall cycles drive the counter into saturation
    cycle(1'b1, 64'h7, 16'h0077, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cycle(($urandom % 4) != 0, {$urandom, $urandom}, CW'($urandom),
            ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
            ($urandom % 100) != 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register; the planned replacement for the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB latches in the 5-stage CPU core.
- Carries a data bundle and a control bundle one stage forward.
- Adds per-entry valid tracking, a valid/ready handshake, hazard stall, branch/jump flush with bubble insertion, and an optional skid entry for registered backpressure.
- One instance per stage boundary in the CPU top.

Parameters:
- DATA_W, 64: width of the data bundle (pc, instruction, operands, ALU result).
- CTRL_W, 16: width of the control bundle (RegWrite, MemWrite, MemRead, Branch, ...); must be at least 1.
- SKID, 0: 1 adds a second entry so ready_o comes straight from a flop; 0 uses a single entry with combinational ready_o.
- CNT_W, 16: width of the performance counters (see Optional Feature).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream holds a valid entry.
- ready_o  out  1  stage can accept an entry this cycle.
- data_i  in  DATA_W  upstream data bundle.
- ctrl_i  in  CTRL_W  upstream control bundle.
- valid_o  out  1  stage holds a valid entry.
- ready_i  in  1  downstream can accept.
- data_o  out  DATA_W  held data bundle.
- ctrl_o  out  CTRL_W  held control bundle; all zeros when valid_o=0.
- stall_i  in  1  hazard-unit hold; forces the effective downstream ready low.
- flush_i  in  1  squash all held entries and the incoming entry.
- stall_cnt_o  out  CNT_W  cycles stalled (feature only; else tied to 0).
- bubble_cnt_o  out  CNT_W  cycles with valid_o=0 (feature only; else tied to 0).

Behaviour:
- Reset (asynchronous, rst_n_i=0): all valid flags 0, data/ctrl registers 0, counters 0. Outputs are therefore valid_o=0, ctrl_o=0, data_o=0. ready_o is 1 immediately after reset is released.
- Definitions:
  - go = ready_i & ~stall_i (effective downstream ready).
  - out_fire = valid_o & go.
  - in_fire = valid_i & ready_o.
- Latency: an accepted entry appears on valid_o/data_o/ctrl_o on the next cycle. Throughput is 1 entry per cycle while go=1.
- SKID=0, single entry:
  - ready_o = ~valid_q | go (combinational).
  - On in_fire: load main entry.
  - On out_fire without in_fire: valid_q <= 0.
- SKID=1, main plus skid entry:
  - ready_o = ~skid_valid_q, taken directly from a flop.
  - in_fire while main is empty, or while out_fire: the entry goes to main.
  - in_fire while main is full and no out_fire: the entry goes to skid.
  - out_fire while skid is full: skid moves to main and skid empties.
  - Entry order is preserved in every case.
- ctrl_o = valid_q ? ctrl_q : 0. This bubble rule guarantees no spurious RegWrite or MemWrite downstream.
- data_o always shows data_q; it is don't-care when valid_o=0.
- Flush:
  - flush_i=1 clears main and skid valid flags on the next edge and zeroes ctrl_q. data_q is retained.
  - An in_fire in the same cycle completes the handshake and the entry is discarded.
  - Flush overrides stall.
- Stall: stall_i=1 holds all entries unchanged. With SKID=1, one further input may still be captured into skid if ready_o=1.
- Simultaneous in_fire and out_fire with a full main entry and an empty skid: main is replaced, no bubble is inserted, and skid stays empty.
- Reset asserted mid-transfer: entries are dropped and no partial state survives.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments every cycle with valid_o & ~go.
  - bubble_cnt_o increments every cycle with ~valid_o.
  - Both saturate at all-ones.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: both outputs are constant 0 and no counter flops are generated.

Decomposition:
- Package pipe_pkg holds:
  - the ctrl bundle typedef (fields RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, MemRead, Branch, Jump, ExtOp, ALUOp[1:0]) and its CTRL_W constant;
  - typedefs for the per-stage data bundles;
  - the constant CTRL_NOP = 0.
- One sub-module, pipe_skid_buf, holds the second entry and its valid flag. It is instantiated only under SKID=1.

Test Plan:
- Streaming, both SKID values: 8 back-to-back entries with data 0x1..0x8 and ready_i=1 -> outputs in the same order, each 1 cycle after input, valid_o continuously high from cycle 1.
- Stall: stall_i=1 for 3 cycles while holding data 0x5 -> data_o=0x5 held; with SKID=0, ready_o=0; with SKID=1, exactly one extra entry 0x6 is absorbed; afterwards 0x5 then 0x6 are delivered.
- Flush: flush_i=1 with one entry held and valid_i=1 (data 0xA) in the same cycle -> next cycle valid_o=0 and ctrl_o=0; 0xA is never output.
- Bubble gating: ctrl_i=0xFFFF, valid_i=0 -> ctrl_o stays 0x0000 and valid_o stays 0.
- Reset mid-stream: rst_n_i low for 1 cycle with the skid entry full -> valid_o=0 and ready_o=1 immediately after reset; no stale entry ever appears.
- PIPE_STAGE_PERF_EN defined, CNT_W=4: 20 stall cycles -> stall_cnt_o saturates at 15.
